// File: rtl/up_pkg.sv
// ----------------------------------------------------------------------------
// up_pkg
//   Shared constants for the accumulator-processor control unit.
//   - Opcode values carried in IR[7:5] (OP_LOAD .. OP_HALT)
//   - FSM state encoding, 4 bits (ST_START .. ST_HALT)
//   - Accumulator mux select codes (ASEL_ADD / ASEL_IN / ASEL_RAM)
//   - ctrl_t: the control word driven towards the datapath
//   - exec_state(): opcode -> execute-state mapping used by DECODE
// ----------------------------------------------------------------------------
package up_pkg;

    localparam int OPW    = 3;  // opcode width (IR[7:5])
    localparam int ASEL_W = 2;  // accumulator-mux select width
    localparam int STW    = 4;  // state register width

    localparam logic [OPW-1:0] OP_LOAD  = 3'b000;
    localparam logic [OPW-1:0] OP_STORE = 3'b001;
    localparam logic [OPW-1:0] OP_ADD   = 3'b010;
    localparam logic [OPW-1:0] OP_SUB   = 3'b011;
    localparam logic [OPW-1:0] OP_INPUT = 3'b100;
    localparam logic [OPW-1:0] OP_JZ    = 3'b101;
    localparam logic [OPW-1:0] OP_JPOS  = 3'b110;
    localparam logic [OPW-1:0] OP_HALT  = 3'b111;

    // Execute states sit at 8..15 so that bit 3 marks "executing";
    // encodings 3..7 are unused and recover to START.
    localparam logic [STW-1:0] ST_START  = 4'h0;
    localparam logic [STW-1:0] ST_FETCH  = 4'h1;
    localparam logic [STW-1:0] ST_DECODE = 4'h2;
    localparam logic [STW-1:0] ST_LOAD   = 4'h8;
    localparam logic [STW-1:0] ST_STORE  = 4'h9;
    localparam logic [STW-1:0] ST_ADD    = 4'hA;
    localparam logic [STW-1:0] ST_SUB    = 4'hB;
    localparam logic [STW-1:0] ST_INPUT  = 4'hC;
    localparam logic [STW-1:0] ST_JZ     = 4'hD;
    localparam logic [STW-1:0] ST_JPOS   = 4'hE;
    localparam logic [STW-1:0] ST_HALT   = 4'hF;

    localparam logic [ASEL_W-1:0] ASEL_ADD = 2'b00;
    localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
    localparam logic [ASEL_W-1:0] ASEL_RAM = 2'b10;

    typedef struct packed {
        logic              ir_load;
        logic              jmp_mux;
        logic              pc_load;
        logic              mem_inst;
        logic              mem_wr;
        logic [ASEL_W-1:0] asel;
        logic              a_load;
        logic              sub;
        logic              halt;
    } ctrl_t;

    function automatic logic [STW-1:0] exec_state(input logic [OPW-1:0] op);
        logic [STW-1:0] st;
        case (op)
            OP_LOAD:  st = ST_LOAD;
            OP_STORE: st = ST_STORE;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_INPUT: st = ST_INPUT;
            OP_JZ:    st = ST_JZ;
            OP_JPOS:  st = ST_JPOS;
            OP_HALT:  st = ST_HALT;
            default:  st = ST_START;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/up_ctrl_decode.sv
// ----------------------------------------------------------------------------
// up_ctrl_decode
//   Combinational control-word decoder. Outputs depend only on the current
//   state, except PCload in JZ/JPOS (follows the flags) and Aload in INPUT
//   (follows Enter).
// Ports
//   state_i  in  4  registered FSM state
//   aeq0_i   in  1  A == 0 flag
//   apos_i   in  1  A > 0 flag
//   enter_i  in  1  operator strobe
//   ctrl_o   out    control word (ctrl_t)
// ----------------------------------------------------------------------------
module up_ctrl_decode
    import up_pkg::*;
(
    input  logic [STW-1:0] state_i,
    input  logic           aeq0_i,
    input  logic           apos_i,
    input  logic           enter_i,
    output ctrl_t          ctrl_o
);

    always_comb begin
        // NOTE: all-zero default before the case keeps every field driven on
        // every path, so no latch is inferred and unlisted states decode to 0.
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.ir_load = 1'b1;
                ctrl_o.pc_load = 1'b1;
            end
            ST_DECODE: ctrl_o.mem_inst = 1'b1;
            ST_LOAD: begin
                ctrl_o.a_load = 1'b1;
                ctrl_o.asel   = ASEL_RAM;
            end
            ST_STORE: begin
                ctrl_o.mem_inst = 1'b1;
                ctrl_o.mem_wr   = 1'b1;
            end
            ST_ADD: begin
                ctrl_o.a_load = 1'b1;
                ctrl_o.asel   = ASEL_ADD;
            end
            ST_SUB: begin
                ctrl_o.a_load = 1'b1;
                ctrl_o.asel   = ASEL_ADD;
                ctrl_o.sub    = 1'b1;
            end
            ST_INPUT: begin
                ctrl_o.a_load = enter_i;
                ctrl_o.asel   = ASEL_IN;
            end
            ST_JZ: begin
                ctrl_o.jmp_mux = 1'b1;
                ctrl_o.pc_load = aeq0_i;
            end
            ST_JPOS: begin
                ctrl_o.jmp_mux = 1'b1;
                ctrl_o.pc_load = apos_i;
            end
            ST_HALT: ctrl_o.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/up_controller.sv
// ----------------------------------------------------------------------------
// up_controller
//   Control unit for the 8-bit accumulator processor. Sequences each
//   instruction START -> FETCH -> DECODE -> EXECUTE. Holds only the state
//   register and next-state logic; the control word comes from
//   up_ctrl_decode.
// Configuration macro
//   CTRL_SINGLE_STEP_EN : adds input Step; START holds until Step=1.
// Ports
//   Clock    in   1  system clock
//   Reset    in   1  synchronous, active-high; forces START
//   Step     in   1  (CTRL_SINGLE_STEP_EN only) run/step enable
//   IR       in   3  opcode IR[7:5]
//   Aeq0     in   1  A == 0
//   Apos     in   1  A > 0
//   Enter    in   1  operator strobe, completes INPUT
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, Halt  out
// ----------------------------------------------------------------------------
module up_controller
    import up_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              Step,
`endif
    input  logic [OPW-1:0]    IR,
    input  logic              Aeq0,
    input  logic              Apos,
    input  logic              Enter,
    output logic              IRload,
    output logic              JMPmux,
    output logic              PCload,
    output logic              Meminst,
    output logic              MemWr,
    output logic [ASEL_W-1:0] Asel,
    output logic              Aload,
    output logic              Sub,
    output logic              Halt
);

    logic [STW-1:0] state_q, state_d;
    ctrl_t          ctrl;

    always_comb begin
        state_d = ST_START;
        case (state_q)
`ifdef CTRL_SINGLE_STEP_EN
            ST_START:  state_d = Step ? ST_FETCH : ST_START;
`else
            ST_START:  state_d = ST_FETCH;
`endif
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = exec_state(IR);
            ST_INPUT:  state_d = Enter ? ST_START : ST_INPUT;
            ST_HALT:   state_d = ST_HALT;
            // One-cycle execute states and illegal encodings return to START.
            default:   state_d = ST_START;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignment for the state register so every
        // reader sees the pre-edge value within the same time step.
        if (Reset) state_q <= ST_START;
        else       state_q <= state_d;
    end

    up_ctrl_decode u_decode (
        .state_i (state_q),
        .aeq0_i  (Aeq0),
        .apos_i  (Apos),
        .enter_i (Enter),
        .ctrl_o  (ctrl)
    );

    assign IRload  = ctrl.ir_load;
    assign JMPmux  = ctrl.jmp_mux;
    assign PCload  = ctrl.pc_load;
    assign Meminst = ctrl.mem_inst;
    assign MemWr   = ctrl.mem_wr;
    assign Asel    = ctrl.asel;
    assign Aload   = ctrl.a_load;
    assign Sub     = ctrl.sub;
    assign Halt    = ctrl.halt;

    // Outside INPUT, at most one of the register/memory load strobes is active.
    a_single_load: assert property (@(posedge Clock) disable iff (Reset)
        (state_q != ST_INPUT) |-> $onehot0({IRload, Aload, MemWr}));

endmodule

// File: tb/tb_up_controller.sv
// ----------------------------------------------------------------------------
// tb_up_controller
//   Self-checking bench for up_controller. Each cycle's inputs and expected
//   control word form one record; records are driven at the falling edge,
//   the expectation is queued and then popped and compared 1 time unit later.
//   Control word packing: {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,Halt}
// ----------------------------------------------------------------------------
module tb_up_controller;

    localparam logic [9:0] E_ZERO    = 10'b00000_00_000;
    localparam logic [9:0] E_FETCH   = 10'b10100_00_000;
    localparam logic [9:0] E_DECODE  = 10'b00010_00_000;
    localparam logic [9:0] E_LOAD    = 10'b00000_10_100;
    localparam logic [9:0] E_STORE   = 10'b00011_00_000;
    localparam logic [9:0] E_ADD     = 10'b00000_00_100;
    localparam logic [9:0] E_SUB     = 10'b00000_00_110;
    localparam logic [9:0] E_IN_WAIT = 10'b00000_01_000;
    localparam logic [9:0] E_IN_GO   = 10'b00000_01_100;
    localparam logic [9:0] E_JMP     = 10'b01000_00_000;
    localparam logic [9:0] E_JMP_PC  = 10'b01100_00_000;
    localparam logic [9:0] E_HALT    = 10'b00000_00_001;

    typedef struct {
        logic       rst;
        logic       step;
        logic [2:0] ir;
        logic       z;
        logic       p;
        logic       en;
        logic [9:0] exp;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Step  = 1'b1;
    logic [2:0] IR    = 3'b000;
    logic       Aeq0  = 1'b0;
    logic       Apos  = 1'b0;
    logic       Enter = 1'b0;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;

    int total = 0;
    int bad   = 0;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    logic [9:0] out_word;

    assign out_word = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};

    up_controller dut (
        .Clock   (Clock),
        .Reset   (Reset),
`ifdef CTRL_SINGLE_STEP_EN
        .Step    (Step),
`endif
        .IR      (IR),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .Enter   (Enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Asel    (Asel),
        .Aload   (Aload),
        .Sub     (Sub),
        .Halt    (Halt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] ir, input logic z,
                                input logic p, input logic en, input logic [9:0] exp,
                                input logic step = 1'b1);
        vec_t v;
        v.rst = rst; v.step = step; v.ir = ir; v.z = z; v.p = p; v.en = en; v.exp = exp;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    // START, FETCH, DECODE, then one execute cycle, flags held throughout.
    task automatic add_instr(input logic [2:0] ir, input logic z, input logic p,
                             input logic en, input logic [9:0] exec_exp);
        add(mk(1'b0, ir, z, p, en, E_ZERO));
        add(mk(1'b0, ir, z, p, en, E_FETCH));
        add(mk(1'b0, ir, z, p, en, E_DECODE));
        add(mk(1'b0, ir, z, p, en, exec_exp));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge Clock);
        Reset = v.rst;
        Step  = v.step;
        IR    = v.ir;
        Aeq0  = v.z;
        Apos  = v.p;
        Enter = v.en;
        exp_q.push_back(v.exp);
        #1;
        check(tag, out_word, exp_q.pop_front());
    endtask

    initial begin
        // Reset held for three checked cycles; all outputs low.
        for (int i = 0; i < 3; i++) add(mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, E_ZERO));
        add_instr(3'b000, 1'b0, 1'b0, 1'b0, E_LOAD);
        add_instr(3'b010, 1'b1, 1'b1, 1'b0, E_ADD);
        add_instr(3'b011, 1'b0, 1'b0, 1'b1, E_SUB);      // Enter outside INPUT ignored
        add_instr(3'b101, 1'b1, 1'b0, 1'b0, E_JMP_PC);   // JZ taken
        add_instr(3'b101, 1'b0, 1'b1, 1'b0, E_JMP);      // JZ not taken, Apos irrelevant
        add_instr(3'b110, 1'b0, 1'b1, 1'b0, E_JMP_PC);   // JPOS taken
        add_instr(3'b110, 1'b1, 1'b0, 1'b0, E_JMP);      // JPOS not taken, Aeq0 irrelevant
        // INPUT: 3 lead-in cycles, 5 waiting, 1 loading = 9 cycles, then START.
        add(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, E_ZERO));
        add(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, E_FETCH));
        add(mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, E_DECODE));
        for (int i = 0; i < 5; i++) add(mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IN_WAIT));
        add(mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, E_IN_GO));
        // STORE lasts exactly one cycle.
        add_instr(3'b001, 1'b0, 1'b0, 1'b0, E_STORE);
        // Reset during FETCH: next cycle is START, not DECODE.
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_ZERO));
        add(mk(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, E_FETCH));
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_ZERO));
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_FETCH));
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_DECODE));
        // Reset during STORE: outputs stay decoded from STORE until the edge.
        add(mk(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, E_STORE));
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_ZERO));
        add(mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, E_FETCH));
        add(mk(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, E_DECODE));  // DECODE selects HALT

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // HALT holds for 20 cycles regardless of Enter, IR and flags.
        for (int i = 0; i < 20; i++) begin
            logic [2:0] rir;
            rir = 3'($urandom_range(7, 0));
            apply(mk(1'b0, rir, i[1], i[2], i[0], E_HALT), $sformatf("halt%0d", i));
        end
        apply(mk(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, E_HALT), "halt_rst");
        apply(mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_ZERO), "halt_start");
        apply(mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FETCH), "halt_fetch");

`ifdef CTRL_SINGLE_STEP_EN
        apply(mk(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, E_DECODE, 1'b0), "ss_rst");
        for (int i = 0; i < 10; i++)
            apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0), $sformatf("ss_hold%0d", i));
        apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b1), "ss_pulse");
        apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_FETCH, 1'b0), "ss_fetch");
        apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_DECODE, 1'b0), "ss_decode");
        apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_ADD, 1'b0), "ss_add");
        for (int i = 0; i < 4; i++)
            apply(mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_ZERO, 1'b0), $sformatf("ss_wait%0d", i));
`endif

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: leftover=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
